// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Shift scoreboard of in-flight register writers; generates
//            forwarding selects, load-use/branch stalls and MUL/DIV R0 interlock.
// Options  : HAZ_STATS_EN adds saturating stall_cnt / fwd_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int BR_LAT   = 1,
  parameter int MC_LAT   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_rs1_used,
  input  logic              issue_rs2_used,
  input  logic              issue_is_branch,
  input  logic              issue_wr_en,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_is_load,
  input  logic              issue_is_mc,
  input  logic              flush,
`ifdef HAZ_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt,
`endif
  output logic [2:0]        fwd_sel_a,
  output logic [2:0]        fwd_sel_b,
  output logic              stall,
  output logic              mc_busy
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  typedef enum logic [0:0] {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mc_state_t;

  logic [DEPTH-1:0]  r_vld;
  logic [DEPTH-1:0]  r_ld;
  logic [DEPTH-1:0]  r_mc;
  logic [REG_AW-1:0] r_rd [DEPTH];

  mc_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic [2:0] w_sel_a, w_sel_b;
  logic       w_ld_a, w_ld_b, w_br_a, w_br_b, w_br_r0;
  logic       w_load_use, w_branch, w_mc_lock, w_stall, w_accept;

  // Descending scan so the youngest (lowest k) match is written last and wins.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    w_br_a  = 1'b0;
    w_br_b  = 1'b0;
    w_br_r0 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (issue_rs1_used && r_vld[k] && (r_rd[k] == issue_rs1)) begin
        w_sel_a = 3'(k + 1);
        w_ld_a  = r_ld[k] && (k < LOAD_LAT);
        w_br_a  = (k < BR_LAT);
      end
      if (issue_rs2_used && r_vld[k] && (r_rd[k] == issue_rs2)) begin
        w_sel_b = 3'(k + 1);
        w_ld_b  = r_ld[k] && (k < LOAD_LAT);
        w_br_b  = (k < BR_LAT);
      end
      // Branches compare against R0 implicitly, so a young R0 writer blocks them.
      if ((k < BR_LAT) && r_vld[k] && (r_mc[k] || (r_rd[k] == '0)))
        w_br_r0 = 1'b1;
    end
  end

  always_comb begin
    w_load_use = w_ld_a || w_ld_b;
    w_branch   = issue_is_branch && (w_br_a || w_br_b || w_br_r0);
    w_mc_lock  = (r_state == MC_BUSY) &&
                 (issue_is_branch || issue_is_mc ||
                  (issue_rs1_used && (issue_rs1 == '0)) ||
                  (issue_rs2_used && (issue_rs2 == '0)) ||
                  (issue_wr_en && (issue_rd == '0)));
    w_stall    = issue_valid && (w_load_use || w_branch || w_mc_lock);
    w_accept   = issue_valid && !w_stall && !flush;
  end

  assign fwd_sel_a = w_sel_a;
  assign fwd_sel_b = w_sel_b;
  assign stall     = w_stall;
  assign mc_busy   = (r_state == MC_BUSY);

  // Older entries keep draining even while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_ld  <= '0;
      r_mc  <= '0;
      for (int k = 0; k < DEPTH; k++) r_rd[k] <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_mc[k]  <= r_mc[k-1];
        r_rd[k]  <= r_rd[k-1];
      end
      r_vld[0] <= w_accept && issue_wr_en;
      r_ld[0]  <= w_accept && issue_is_load;
      r_mc[0]  <= w_accept && issue_is_mc;
      r_rd[0]  <= w_accept ? issue_rd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MC_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MC_IDLE: begin
        if (w_accept && issue_is_mc) begin
          w_state_nxt = MC_BUSY;
          w_cnt_nxt   = CW'(MC_LAT - 1);
        end
      end
      MC_BUSY: begin
        if (r_cnt == '0) w_state_nxt = MC_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = MC_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HAZ_STATS_EN
  logic [31:0] r_stall_cnt, r_fwd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (((w_sel_a != '0) || (w_sel_b != '0)) && (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule
`default_nettype wire
